// File: rtl/euler_step_sequencer_if.sv
// Term-producer / accumulator side of the Euler step sequencer.
// master = sequencer, slave = term producer plus accumulator.
interface euler_step_sequencer_if #(
  parameter int Size = 16
) ();
  logic            term_valid;
  logic [Size-1:0] term;
  logic            term_ready;
  logic            acc_rst_sync;
  logic [Size-1:0] acc_inp;
  logic            acc_out_en;
  logic            acc_overflow;

  modport master (
    input  term_valid, term, acc_overflow,
    output term_ready, acc_rst_sync, acc_inp, acc_out_en
  );

  modport slave (
    output term_valid, term, acc_overflow,
    input  term_ready, acc_rst_sync, acc_inp, acc_out_en
  );
endinterface

// File: rtl/euler_step_sequencer.sv
// Drives one shared accumulator through x[n+1] = x[n] + h*f(x[n]) for num_steps steps.
//   state | meaning
//   IDLE  | waiting for start; accumulator output shown while result_valid
//   CLEAR | synchronous accumulator clear, capture num_steps and x0
//   LOAD  | add x0 into the cleared accumulator
//   STEP  | accept one increment term per handshake
//   DONE  | one-cycle completion pulse, result now valid
//   ERR   | overflow seen, set sticky error
module euler_step_sequencer #(
  parameter int Size  = 16,
  parameter int StepW = 8
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              start,
  input  logic              abort,
  input  logic [StepW-1:0]  num_steps,
  input  logic [Size-1:0]   x0,
  euler_step_sequencer_if.master bus,
  output logic [StepW-1:0]  step_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_LOAD, ST_STEP, ST_DONE, ST_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [StepW-1:0] steps_q, steps_d;
  logic [StepW-1:0] step_idx_q, step_idx_d;
  logic [Size-1:0]  x0_q, x0_d;
  logic             result_valid_q, result_valid_d;
  logic             error_q, error_d;
  logic [StepW-1:0] step_next;

  // step_idx stays below steps_q while stepping, so this sum cannot wrap
  assign step_next = step_idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q        <= ST_IDLE;
      steps_q        <= '0;
      step_idx_q     <= '0;
      x0_q           <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      steps_q        <= steps_d;
      step_idx_q     <= step_idx_d;
      x0_q           <= x0_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    steps_d          = steps_q;
    step_idx_d       = step_idx_q;
    x0_d             = x0_q;
    result_valid_d   = result_valid_q;
    error_d          = error_q;
    bus.term_ready   = 1'b0;
    bus.acc_rst_sync = 1'b0;
    bus.acc_inp      = '0;
    bus.acc_out_en   = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus.acc_out_en = result_valid_q;
        if (start) begin
          error_d        = 1'b0;
          result_valid_d = 1'b0;
          state_d        = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy             = 1'b1;
        bus.acc_rst_sync = 1'b1;
        steps_d          = num_steps;
        x0_d             = x0;
        step_idx_d       = '0;
        state_d          = abort ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          bus.acc_rst_sync = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          bus.acc_inp = x0_q;
          state_d     = (steps_q == '0) ? ST_DONE : ST_STEP;
        end
      end
      ST_STEP: begin
        busy = 1'b1;
        if (abort) begin
          // abort wins over a handshake in the same cycle
          bus.acc_rst_sync = 1'b1;
          state_d          = ST_IDLE;
        end else begin
          bus.term_ready = 1'b1;
          bus.acc_out_en = 1'b1;
          if (bus.term_valid) begin
            bus.acc_inp = bus.term;
            if (bus.acc_overflow) begin
              state_d = ST_ERR;
            end else begin
              step_idx_d = step_next;
              if (step_next == steps_q) state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        done           = 1'b1;
        bus.acc_out_en = 1'b1;
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_ERR: begin
        error_d        = 1'b1;
        result_valid_d = 1'b0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step_idx = step_idx_q;
  assign error    = error_q;

endmodule
